// File: rtl/sdma_port_ready_sel_if.sv
// ----------------------------------------------------------------------------
// sdma_port_ready_sel_if
// Purpose : bundles the instruction handshake, per-port ready inputs, request
//           strobes and the selected ready / status outputs of
//           sdma_port_ready_sel into one interface.
// Modports:
//   master - SDMA controller side: drives instruction/port/request inputs,
//            observes selected ready and status flags.
//   slave  - the ready selector itself.
// Signals :
//   i_inst_start, i_inst_done            instruction start / finish pulses
//   i_inst_srcportid, i_inst_dstportid   port IDs, valid with start
//   i_port_ready [NPORT]                 per-port ready, bit k = port k
//   i_sport_req, i_dport_req             per-side transfer request
//   i_tmo_limit  [TMO_W]                 stall limit, 0 disables timeout
//   o_sdma_sportready, o_sdma_dportready selected, gated ready
//   o_sel_valid                          selection latched
//   o_badpid [2]                         sticky {dst,src} unmapped ID
//   o_sport_tmo, o_dport_tmo             sticky stall timeouts
// ----------------------------------------------------------------------------
interface sdma_port_ready_sel_if #(
  parameter int NPORT = 5,
  parameter int PID_W = 3,
  parameter int TMO_W = 16
) ();
  logic             i_inst_start;
  logic             i_inst_done;
  logic [PID_W-1:0] i_inst_srcportid;
  logic [PID_W-1:0] i_inst_dstportid;
  logic [NPORT-1:0] i_port_ready;
  logic             i_sport_req;
  logic             i_dport_req;
  logic [TMO_W-1:0] i_tmo_limit;
  logic             o_sdma_sportready;
  logic             o_sdma_dportready;
  logic             o_sel_valid;
  logic [1:0]       o_badpid;
  logic             o_sport_tmo;
  logic             o_dport_tmo;

  modport master (
    output i_inst_start, i_inst_done, i_inst_srcportid, i_inst_dstportid,
    output i_port_ready, i_sport_req, i_dport_req, i_tmo_limit,
    input  o_sdma_sportready, o_sdma_dportready, o_sel_valid, o_badpid,
    input  o_sport_tmo, o_dport_tmo
  );

  modport slave (
    input  i_inst_start, i_inst_done, i_inst_srcportid, i_inst_dstportid,
    input  i_port_ready, i_sport_req, i_dport_req, i_tmo_limit,
    output o_sdma_sportready, o_sdma_dportready, o_sel_valid, o_badpid,
    output o_sport_tmo, o_dport_tmo
  );
endinterface

// File: rtl/sdma_port_ready_sel.sv
// ----------------------------------------------------------------------------
// sdma_port_ready_sel
// Purpose : instruction-scoped ready selector. At an accepted instruction
//           start the source and destination port IDs are mapped through
//           PID_MAP to one of NPORT ready inputs; the chosen ready bits are
//           driven out (gated by the selection being valid). Per-side stall
//           counters raise sticky timeout flags; an unmapped ID falls back
//           to port 0 and raises a sticky badpid bit.
// Ports   :
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      sdma_port_ready_sel_if.slave (handshake, ready inputs, status)
// ----------------------------------------------------------------------------
module sdma_port_ready_sel #(
  parameter int                     NPORT   = 5,
  parameter int                     PID_W   = 3,
  parameter logic [NPORT*PID_W-1:0] PID_MAP = {3'b111, 3'b110, 3'b101, 3'b100, 3'b000},
  parameter int                     TMO_W   = 16,
  parameter bit                     REG_OUT = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sdma_port_ready_sel_if.slave bus
);

  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_STALLED = 2'd2;

  // Returns {miss, index}. Scanning from the top down lets the lowest
  // matching slot win; a miss leaves index 0 (the fallback port).
  function automatic logic [IDX_W:0] f_decode(input logic [PID_W-1:0] id);
    logic [IDX_W:0] res;
    res        = '0;
    res[IDX_W] = 1'b1;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (PID_MAP[k*PID_W +: PID_W] == id) res = {1'b0, IDX_W'(k)};
    end
    return res;
  endfunction

  // Stall count update: saturate at the limit while stalled, clear on a
  // completed beat, hold when the side is not requesting.
  function automatic logic [TMO_W-1:0] f_cnt_next(input logic [TMO_W-1:0] cnt,
                                                  input logic             req,
                                                  input logic             rdy,
                                                  input logic [TMO_W-1:0] lim);
    logic [TMO_W-1:0] res;
    res = cnt;
    if (req && !rdy) begin
      if (cnt < lim) res = cnt + 1'b1;
    end else if (req) begin
      res = '0;
    end
    return res;
  endfunction

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_src_sel;
  logic [IDX_W-1:0] r_dst_sel;
  logic [1:0]       r_badpid;
  logic [TMO_W-1:0] r_scnt;
  logic [TMO_W-1:0] r_dcnt;
  logic             r_stmo;
  logic             r_dtmo;

  logic             w_valid;
  logic             w_active;
  logic             w_load;
  logic             w_release;
  logic             w_sready;
  logic             w_dready;
  logic             w_stmo_set;
  logic             w_dtmo_set;
  logic [TMO_W-1:0] w_scnt_nxt;
  logic [TMO_W-1:0] w_dcnt_nxt;
  logic [IDX_W:0]   w_src_dec;
  logic [IDX_W:0]   w_dst_dec;

  assign w_valid  = (r_state != S_IDLE);
  assign w_active = (r_state == S_ACTIVE);

  // A start is accepted from IDLE, or together with done while busy
  // (release and reload in one cycle). A lone start while busy is dropped.
  assign w_load    = bus.i_inst_start & (~w_valid | bus.i_inst_done);
  assign w_release = bus.i_inst_done & w_valid & ~bus.i_inst_start;

  assign w_src_dec = f_decode(bus.i_inst_srcportid);
  assign w_dst_dec = f_decode(bus.i_inst_dstportid);

  assign w_sready = bus.i_port_ready[r_src_sel] & w_valid;
  assign w_dready = bus.i_port_ready[r_dst_sel] & w_valid;

  assign w_scnt_nxt = f_cnt_next(r_scnt, bus.i_sport_req, w_sready, bus.i_tmo_limit);
  assign w_dcnt_nxt = f_cnt_next(r_dcnt, bus.i_dport_req, w_dready, bus.i_tmo_limit);

  // Compared against the live limit, so lowering it under an existing count
  // trips the timeout on the next edge even without further stalls.
  assign w_stmo_set = w_active & (bus.i_tmo_limit != '0) & (w_scnt_nxt >= bus.i_tmo_limit);
  assign w_dtmo_set = w_active & (bus.i_tmo_limit != '0) & (w_dcnt_nxt >= bus.i_tmo_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_src_sel <= '0;
      r_dst_sel <= '0;
      r_badpid  <= 2'b00;
      r_scnt    <= '0;
      r_dcnt    <= '0;
      r_stmo    <= 1'b0;
      r_dtmo    <= 1'b0;
    end else if (w_load) begin
      r_state   <= S_ACTIVE;
      r_src_sel <= w_src_dec[IDX_W-1:0];
      r_dst_sel <= w_dst_dec[IDX_W-1:0];
      r_badpid  <= {w_dst_dec[IDX_W], w_src_dec[IDX_W]};
      r_scnt    <= '0;
      r_dcnt    <= '0;
      r_stmo    <= 1'b0;
      r_dtmo    <= 1'b0;
    end else begin
      // Counters only move in ACTIVE; STALLED freezes them for the controller.
      if (w_active) begin
        r_scnt <= w_scnt_nxt;
        r_dcnt <= w_dcnt_nxt;
        r_stmo <= r_stmo | w_stmo_set;
        r_dtmo <= r_dtmo | w_dtmo_set;
      end
      if (w_release) begin
        r_state <= S_IDLE;
      end else if (w_stmo_set || w_dtmo_set) begin
        r_state <= S_STALLED;
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic r_sready;
      logic r_dready;
      logic w_drop;

      // Drop ready on the same edge the selection is released or reloaded,
      // so a registered ready never outlives its instruction.
      assign w_drop = bus.i_inst_done & w_valid;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sready <= 1'b0;
          r_dready <= 1'b0;
        end else begin
          r_sready <= w_sready & ~w_drop;
          r_dready <= w_dready & ~w_drop;
        end
      end

      assign bus.o_sdma_sportready = r_sready;
      assign bus.o_sdma_dportready = r_dready;
    end else begin : g_comb
      assign bus.o_sdma_sportready = w_sready;
      assign bus.o_sdma_dportready = w_dready;
    end
  endgenerate

  assign bus.o_sel_valid = w_valid;
  assign bus.o_badpid    = r_badpid;
  assign bus.o_sport_tmo = r_stmo;
  assign bus.o_dport_tmo = r_dtmo;

endmodule

// File: tb/tb_sdma_port_ready_sel.sv
module tb_sdma_port_ready_sel;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  sdma_port_ready_sel_if #(.NPORT(5), .PID_W(3), .TMO_W(16)) bus ();

  sdma_port_ready_sel #(.REG_OUT(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: transaction-level view of the selector.
  int id_table [5] = '{0: 0, 1: 4, 2: 5, 3: 6, 4: 7};
  bit m_valid, m_stall, m_sr, m_dr, m_stmo, m_dtmo;
  bit [1:0] m_bad;
  int m_src, m_dst, m_scnt, m_dcnt;

  function automatic int lookup(input int id);
    for (int k = 0; k < 5; k++) if (id_table[k] == id) return k;
    return -1;
  endfunction

  function automatic int stall_upd(input int cnt, input bit req, input bit rdy, input int lim);
    if (req && !rdy) return (cnt < lim) ? cnt + 1 : cnt;
    if (req) return 0;
    return cnt;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_stall = 0; m_sr = 0; m_dr = 0; m_stmo = 0; m_dtmo = 0;
    m_bad = 2'b00; m_src = 0; m_dst = 0; m_scnt = 0; m_dcnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sel_valid", {31'b0, bus.o_sel_valid}, {31'b0, m_valid});
    chk("sportready", {31'b0, bus.o_sdma_sportready}, {31'b0, m_sr});
    chk("dportready", {31'b0, bus.o_sdma_dportready}, {31'b0, m_dr});
    chk("badpid", {30'b0, bus.o_badpid}, {30'b0, m_bad});
    chk("sport_tmo", {31'b0, bus.o_sport_tmo}, {31'b0, m_stmo});
    chk("dport_tmo", {31'b0, bus.o_dport_tmo}, {31'b0, m_dtmo});
  endtask

  // Evaluate the model on the inputs present before the edge, clock, then
  // compare every output against the model.
  task automatic tick();
    bit st, dn, rs, rd, load, rel, act;
    int lim, s, d;
    st  = bus.i_inst_start;
    dn  = bus.i_inst_done;
    lim = int'(bus.i_tmo_limit);
    rs  = m_valid && bus.i_port_ready[m_src];
    rd  = m_valid && bus.i_port_ready[m_dst];
    load = st && (!m_valid || dn);
    rel  = dn && m_valid && !st;
    act  = m_valid && !m_stall;
    m_sr = rs && !(dn && m_valid);
    m_dr = rd && !(dn && m_valid);
    if (load) begin
      s = lookup(int'(bus.i_inst_srcportid));
      d = lookup(int'(bus.i_inst_dstportid));
      m_bad = {d < 0, s < 0};
      m_src = (s < 0) ? 0 : s;
      m_dst = (d < 0) ? 0 : d;
      m_scnt = 0; m_dcnt = 0; m_stmo = 0; m_dtmo = 0;
      m_valid = 1; m_stall = 0;
    end else begin
      if (act) begin
        m_scnt = stall_upd(m_scnt, bus.i_sport_req, rs, lim);
        m_dcnt = stall_upd(m_dcnt, bus.i_dport_req, rd, lim);
        if (lim != 0 && m_scnt >= lim) m_stmo = 1;
        if (lim != 0 && m_dcnt >= lim) m_dtmo = 1;
      end
      if (rel) begin
        m_valid = 0; m_stall = 0;
      end else if (act && (m_stmo || m_dtmo)) begin
        m_stall = 1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic start_inst(input logic [2:0] src, input logic [2:0] dst, input bit with_done);
    bus.i_inst_srcportid = src;
    bus.i_inst_dstportid = dst;
    bus.i_inst_start     = 1'b1;
    bus.i_inst_done      = with_done;
    tick();
    bus.i_inst_start     = 1'b0;
    bus.i_inst_done      = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.i_inst_start = 1'b0; bus.i_inst_done = 1'b0;
    bus.i_inst_srcportid = '0; bus.i_inst_dstportid = '0;
    bus.i_port_ready = 5'b11111; bus.i_sport_req = 1'b0; bus.i_dport_req = 1'b0;
    bus.i_tmo_limit = '0;
    #22;
    chk("rst_sel_valid", {31'b0, bus.o_sel_valid}, 32'd0);
    chk("rst_sportready", {31'b0, bus.o_sdma_sportready}, 32'd0);
    chk("rst_dportready", {31'b0, bus.o_sdma_dportready}, 32'd0);
    chk("rst_badpid", {30'b0, bus.o_badpid}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic selection with registered outputs.
    bus.i_port_ready = 5'b00011;
    start_inst(3'b100, 3'b000, 1'b0);
    chk("t1_valid_next", {31'b0, bus.o_sel_valid}, 32'd1);
    chk("t1_sready_early", {31'b0, bus.o_sdma_sportready}, 32'd0);
    tick();
    chk("t1_sready", {31'b0, bus.o_sdma_sportready}, 32'd1);
    chk("t1_dready", {31'b0, bus.o_sdma_dportready}, 32'd1);
    tick();
    bus.i_inst_done = 1'b1; tick(); bus.i_inst_done = 1'b0;
    chk("t1_done_sready", {31'b0, bus.o_sdma_sportready}, 32'd0);
    chk("t1_done_dready", {31'b0, bus.o_sdma_dportready}, 32'd0);
    chk("t1_done_valid", {31'b0, bus.o_sel_valid}, 32'd0);
    bus.i_port_ready = 5'b11110; tick();
    chk("t1_idle_sready", {31'b0, bus.o_sdma_sportready}, 32'd0);

    // Unmapped source ID falls back to port 0 and stays flagged.
    bus.i_port_ready = 5'b00001;
    start_inst(3'b010, 3'b000, 1'b0);
    chk("t2_badpid", {30'b0, bus.o_badpid}, 32'd1);
    tick();
    chk("t2_fallback_sready", {31'b0, bus.o_sdma_sportready}, 32'd1);
    bus.i_inst_done = 1'b1; tick(); bus.i_inst_done = 1'b0;
    tick();
    chk("t2_badpid_after_done", {30'b0, bus.o_badpid}, 32'd1);

    // Stall timeout at limit 4.
    bus.i_tmo_limit = 16'd4;
    bus.i_port_ready = 5'b00001;
    start_inst(3'b100, 3'b000, 1'b0);
    bus.i_sport_req = 1'b1;
    tick(); tick(); tick();
    chk("t3_no_tmo_yet", {31'b0, bus.o_sport_tmo}, 32'd0);
    tick();
    chk("t3_tmo", {31'b0, bus.o_sport_tmo}, 32'd1);
    chk("t3_dtmo_clear", {31'b0, bus.o_dport_tmo}, 32'd0);
    tick(); tick();
    chk("t3_stalled_valid", {31'b0, bus.o_sel_valid}, 32'd1);
    bus.i_sport_req = 1'b0;
    bus.i_inst_done = 1'b1; tick(); bus.i_inst_done = 1'b0;
    chk("t3_tmo_holds_idle", {31'b0, bus.o_sport_tmo}, 32'd1);

    // Limit 0 disables timeouts.
    bus.i_tmo_limit = 16'd0;
    start_inst(3'b100, 3'b000, 1'b0);
    bus.i_sport_req = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("t3_no_tmo_lim0", {31'b0, bus.o_sport_tmo}, 32'd0);
    bus.i_sport_req = 1'b0;
    bus.i_inst_done = 1'b1; tick(); bus.i_inst_done = 1'b0;

    // Lowering the live limit below the count trips the timeout.
    bus.i_tmo_limit = 16'd10;
    start_inst(3'b100, 3'b011, 1'b0);
    bus.i_sport_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_lim10_no_tmo", {31'b0, bus.o_sport_tmo}, 32'd0);
    bus.i_sport_req = 1'b0;
    bus.i_tmo_limit = 16'd2;
    tick();
    chk("t3_lowered_tmo", {31'b0, bus.o_sport_tmo}, 32'd1);
    chk("t3_dst_badpid", {30'b0, bus.o_badpid}, 32'd2);

    // Start and done together while stalled reload the selection.
    bus.i_tmo_limit = 16'd0;
    bus.i_port_ready = 5'b10000;
    start_inst(3'b100, 3'b111, 1'b1);
    chk("t4_badpid_clr", {30'b0, bus.o_badpid}, 32'd0);
    chk("t4_tmo_clr", {31'b0, bus.o_sport_tmo}, 32'd0);
    chk("t4_valid", {31'b0, bus.o_sel_valid}, 32'd1);
    tick();
    chk("t4_dready_port4", {31'b0, bus.o_sdma_dportready}, 32'd1);
    chk("t4_sready_port1", {31'b0, bus.o_sdma_sportready}, 32'd0);

    // Lone start while active is ignored.
    start_inst(3'b000, 3'b000, 1'b0);
    tick();
    chk("t5_dready_kept", {31'b0, bus.o_sdma_dportready}, 32'd1);
    chk("t5_sready_kept", {31'b0, bus.o_sdma_sportready}, 32'd0);

    // Asynchronous reset in the middle of a stall.
    bus.i_tmo_limit = 16'd3;
    bus.i_sport_req = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, bus.o_sel_valid}, 32'd0);
    chk("t6_rst_dready", {31'b0, bus.o_sdma_dportready}, 32'd0);
    chk("t6_rst_sready", {31'b0, bus.o_sdma_sportready}, 32'd0);
    chk("t6_rst_tmo", {31'b0, bus.o_sport_tmo}, 32'd0);
    model_reset();
    bus.i_sport_req = 1'b0;
    bus.i_tmo_limit = 16'd0;
    bus.i_port_ready = 5'b11111;
    #2 rst_n = 1'b1;
    tick();
    chk("t6_idle_valid", {31'b0, bus.o_sel_valid}, 32'd0);
    chk("t6_idle_sready", {31'b0, bus.o_sdma_sportready}, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.i_inst_start     = ($urandom_range(0, 7) == 0);
      bus.i_inst_done      = ($urandom_range(0, 9) == 0);
      bus.i_inst_srcportid = 3'($urandom_range(0, 7));
      bus.i_inst_dstportid = 3'($urandom_range(0, 7));
      bus.i_port_ready     = 5'($urandom);
      bus.i_sport_req      = 1'($urandom);
      bus.i_dport_req      = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus.i_tmo_limit = 16'($urandom_range(0, 6));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
